spi_slave: RTL and testbench

// - SPI responder (mode 0: CPOL=0, CPHA=0, MSB first), the target end of the team's SPI master.
// - Oversamples spi_clk/cs/mosi in the system clock domain. Shifts a byte out on miso while shifting a byte in from mosi.
// - Supports back-to-back bytes within one cs-low frame. Sits between the board SPI pins and a local register/FIFO client.

---
 rtl/spi_slave_pkg.sv | 21 ++
 rtl/spi_slave_if.sv | 34 +++
 rtl/spi_sync_edge.sv | 41 ++++
 rtl/spi_slave.sv | 142 ++++++++++++++
 tb/tb_spi_slave.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// spi_slave_pkg : shared FSM encodings, SPI mode and default sizing
// Revision      : 1.0
// ============================================================================
package spi_slave_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// spi_slave_if : SPI pins plus the local tx/rx client handshake
// Revision     : 1.0
// ============================================================================
interface spi_slave_if import spi_slave_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             spi_clk;
  logic             cs;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             busy;

  modport slave (
    input  spi_clk, cs, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output spi_clk, cs, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// spi_sync_edge : multi-flop synchronizer with rise/fall detection
// Revision      : 1.0
// ============================================================================
module spi_sync_edge import spi_slave_pkg::*; #(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic async_in,
  output logic      sync_out,
  output logic      rise,
  output logic      fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  // Resetting to 0 means a cs held low through reset never yields a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise     =  sync_out & ~prev_q;
  assign fall     = ~sync_out &  prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// spi_slave : mode-0 SPI responder with a one-entry tx holding register
// Revision  : 1.0
// ============================================================================
module spi_slave import spi_slave_pkg::*; #(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter logic [WIDTH-1:0] IDLE_FILL   = {WIDTH{1'b1}}
) (
  input wire logic   clk,
  input wire logic   reset,
  spi_slave_if.slave bus
);

  localparam int   CNT_W          = $clog2(WIDTH);
  localparam logic SAMPLE_ON_FALL = SPI_CPOL ^ SPI_CPHA;

  logic sclk_rise, sclk_fall, sclk_s_unused;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic sample_edge, shift_edge;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .async_in(bus.spi_clk),
    .sync_out(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .async_in(bus.cs),
    .sync_out(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .async_in(bus.mosi),
    .sync_out(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign sample_edge = SAMPLE_ON_FALL ? sclk_fall : sclk_rise;
  assign shift_edge  = SAMPLE_ON_FALL ? sclk_rise : sclk_fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             load_tx, consume, underrun, accept;

  assign accept = bus.tx_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    load_tx     = 1'b0;
    consume     = 1'b0;
    underrun    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_tx   = 1'b1;
        bit_cnt_d = '0;
        state_d   = cs_rise ? ST_IDLE : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[WIDTH-3:0], mosi_s};
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
              bit_cnt_d  = '0;
              rx_data_d  = {rx_shift_q, mosi_s};
              rx_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          // A shift edge at bit 0 only follows a completed word: fetch the next one.
          if (shift_edge) begin
            if (bit_cnt_q != '0) tx_shift_d = tx_shift_q << 1;
            else                 load_tx    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_tx) begin
      if (hold_full_q) begin
        tx_shift_d = hold_q;
        consume    = 1'b1;
      end else begin
        tx_shift_d = IDLE_FILL;
        underrun   = 1'b1;
      end
    end

    hold_full_d = (hold_full_q & ~consume) | accept;
    hold_d      = accept ? bus.tx_data : hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Output enable follows synced cs directly so it drops on the cs_rise cycle.
  assign bus.miso_oe     = (state_q != ST_IDLE) & ~cs_s;
  assign bus.busy        = bus.miso_oe;
  assign bus.miso        = tx_shift_q[WIDTH-1] & bus.miso_oe;
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// tb_spi_slave : behavioural mode-0 master driving spi_slave, queue scoreboard
// Revision     : 1.0
// ============================================================================
module tb_spi_slave;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  spi_slave_if #(.WIDTH(8)) bus ();

  spi_slave #(.WIDTH(8), .SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] obs_miso[$];

  // Monitor: logs DUT output events, sampled 1 ns after the falling edge.
  logic [7:0] rx_log [0:63];
  int         und_log[0:63];
  int         rx_total  = 0;
  int         und_total = 0;
  int         acc_total = 0;

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (bus.rx_valid) begin
        if (rx_total < 64) rx_log[rx_total] = bus.rx_data;
        rx_total++;
      end
      if (bus.tx_underrun) begin
        if (und_total < 64) und_log[und_total] = rx_total;
        und_total++;
      end
      if (bus.tx_valid && bus.tx_ready) acc_total++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic push_tx(input logic [7:0] d);
    int n = 0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL push_tx_timeout: tx_ready never seen for %h", d);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (8) @(negedge clk);
    bus.cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = tx[7-i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], bus.miso};
      bus.spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    logic [7:0] r;
    exp_rx.push_back(tx);
    spi_bits(tx, 8, r);
    obs_miso.push_back(r);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.miso !== 1'b0)        begin failures++; $display("FAIL reset_miso: got %b want 0", bus.miso); end
    checks++; if (bus.miso_oe !== 1'b0)     begin failures++; $display("FAIL reset_miso_oe: got %b want 0", bus.miso_oe); end
    checks++; if (bus.tx_ready !== 1'b1)    begin failures++; $display("FAIL reset_tx_ready: got %b want 1", bus.tx_ready); end
    checks++; if (bus.rx_data !== 8'h00)    begin failures++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0)    begin failures++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
    checks++; if (bus.tx_underrun !== 1'b0) begin failures++; $display("FAIL reset_tx_underrun: got %b want 0", bus.tx_underrun); end
    checks++; if (bus.busy !== 1'b0)        begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int rb = rx_total;
    logic [7:0] e;
    push_tx(8'hA5);
    exp_miso.push_back(8'hA5);
    cs_low();
    spi_byte(8'h3C);
    cs_high();
    checks++; if (rx_total - rb !== 1) begin failures++; $display("FAIL single_rx_count: got %0d want 1", rx_total - rb); end
    e = exp_rx.pop_front();
    checks++; if (rx_log[rb] !== e)    begin failures++; $display("FAIL single_rx_word: got %h want %h", rx_log[rb], e); end
    e = exp_miso.pop_front();
    checks++; if (obs_miso[0] !== e)   begin failures++; $display("FAIL single_miso: got %h want %h", obs_miso[0], e); end
    void'(obs_miso.pop_front());
    checks++; if (bus.rx_data !== 8'h3C) begin failures++; $display("FAIL single_rx_data_held: got %h want 3c", bus.rx_data); end
    checks++; if (bus.tx_ready !== 1'b1) begin failures++; $display("FAIL single_tx_ready: got %b want 1", bus.tx_ready); end
  endtask

  task automatic test_back_to_back();
    int rb = rx_total;
    int k = 0;
    logic [7:0] e;
    push_tx(8'h11);
    exp_miso.push_back(8'h11);
    cs_low();
    push_tx(8'h22);
    exp_miso.push_back(8'h22);
    spi_byte(8'hF0);
    spi_byte(8'h0F);
    cs_high();
    checks++; if (rx_total - rb !== 2) begin failures++; $display("FAIL b2b_rx_count: got %0d want 2", rx_total - rb); end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      checks++; if (rx_log[rb+k] !== e) begin failures++; $display("FAIL b2b_rx_word%0d: got %h want %h", k, rx_log[rb+k], e); end
      k++;
    end
    k = 0;
    while (exp_miso.size() > 0) begin
      e = exp_miso.pop_front();
      checks++; if (obs_miso[0] !== e) begin failures++; $display("FAIL b2b_miso%0d: got %h want %h", k, obs_miso[0], e); end
      void'(obs_miso.pop_front());
      k++;
    end
  endtask

  task automatic test_underrun();
    int rb = rx_total;
    int ub = und_total;
    int at_load = 0;
    logic [7:0] e;
    exp_miso.push_back(8'hFF);
    cs_low();
    spi_byte(8'h55);
    cs_high();
    for (int i = ub; i < und_total && i < 64; i++)
      if (und_log[i] == rb) at_load++;
    checks++; if (at_load !== 1)       begin failures++; $display("FAIL underrun_pulses_in_word: got %0d want 1", at_load); end
    checks++; if (rx_total - rb !== 1) begin failures++; $display("FAIL underrun_rx_count: got %0d want 1", rx_total - rb); end
    e = exp_rx.pop_front();
    checks++; if (rx_log[rb] !== e)    begin failures++; $display("FAIL underrun_rx_word: got %h want %h", rx_log[rb], e); end
    e = exp_miso.pop_front();
    checks++; if (obs_miso[0] !== e)   begin failures++; $display("FAIL underrun_miso: got %h want %h", obs_miso[0], e); end
    void'(obs_miso.pop_front());
  endtask

  task automatic test_abort();
    int rb = rx_total;
    logic [7:0] r, e;
    cs_low();
    spi_bits(8'hC3, 5, r);
    cs_high();
    checks++; if (rx_total !== rb)       begin failures++; $display("FAIL abort_rx_valid: got %0d pulses want 0", rx_total - rb); end
    checks++; if (bus.rx_data !== 8'h55) begin failures++; $display("FAIL abort_rx_data: got %h want 55", bus.rx_data); end
    exp_miso.push_back(8'hFF);
    cs_low();
    spi_byte(8'h81);
    cs_high();
    checks++; if (rx_total - rb !== 1)   begin failures++; $display("FAIL abort_next_count: got %0d want 1", rx_total - rb); end
    e = exp_rx.pop_front();
    checks++; if (rx_log[rb] !== e)      begin failures++; $display("FAIL abort_next_word: got %h want %h", rx_log[rb], e); end
    checks++; if (bus.rx_data !== 8'h81) begin failures++; $display("FAIL abort_next_rx_data: got %h want 81", bus.rx_data); end
    e = exp_miso.pop_front();
    checks++; if (obs_miso[0] !== e)     begin failures++; $display("FAIL abort_next_miso: got %h want %h", obs_miso[0], e); end
    void'(obs_miso.pop_front());
  endtask

  task automatic test_reset_mid_frame();
    int rb = rx_total;
    logic [7:0] r, e;
    logic [7:0] rest = 8'hB4 << 3;
    cs_low();
    push_tx(8'hC6);
    spi_bits(8'hB4, 3, r);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.miso !== 1'b0)        begin failures++; $display("FAIL rmid_miso: got %b want 0", bus.miso); end
    checks++; if (bus.miso_oe !== 1'b0)     begin failures++; $display("FAIL rmid_miso_oe: got %b want 0", bus.miso_oe); end
    checks++; if (bus.busy !== 1'b0)        begin failures++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.tx_ready !== 1'b1)    begin failures++; $display("FAIL rmid_tx_ready: got %b want 1", bus.tx_ready); end
    checks++; if (bus.rx_data !== 8'h00)    begin failures++; $display("FAIL rmid_rx_data: got %h want 00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0)    begin failures++; $display("FAIL rmid_rx_valid: got %b want 0", bus.rx_valid); end
    checks++; if (bus.tx_underrun !== 1'b0) begin failures++; $display("FAIL rmid_tx_underrun: got %b want 0", bus.tx_underrun); end
    reset = 1'b0;
    spi_bits(rest, 5, r);
    checks++; if (bus.busy !== 1'b0)  begin failures++; $display("FAIL rmid_ignored_busy: got %b want 0", bus.busy); end
    checks++; if (rx_total !== rb)    begin failures++; $display("FAIL rmid_ignored_rx: got %0d pulses want 0", rx_total - rb); end
    cs_high();
    push_tx(8'h5A);
    exp_miso.push_back(8'h5A);
    cs_low();
    spi_byte(8'hE7);
    cs_high();
    checks++; if (rx_total - rb !== 1) begin failures++; $display("FAIL rmid_next_count: got %0d want 1", rx_total - rb); end
    e = exp_rx.pop_front();
    checks++; if (rx_log[rb] !== e)    begin failures++; $display("FAIL rmid_next_word: got %h want %h", rx_log[rb], e); end
    e = exp_miso.pop_front();
    checks++; if (obs_miso[0] !== e)   begin failures++; $display("FAIL rmid_next_miso: got %h want %h", obs_miso[0], e); end
    void'(obs_miso.pop_front());
  endtask

  task automatic test_handshake();
    int rb = rx_total;
    int ub = und_total;
    int ab = acc_total;
    int k = 0;
    logic [7:0] e;
    // Expected accepts: initial fill, refill after LOAD, refill after each word end.
    bus.tx_data  = 8'h77;
    bus.tx_valid = 1'b1;
    exp_miso.push_back(8'h77);
    exp_miso.push_back(8'h77);
    cs_low();
    spi_byte(8'h12);
    spi_byte(8'h34);
    cs_high();
    checks++; if (bus.tx_ready !== 1'b0) begin failures++; $display("FAIL hs_tx_ready_full: got %b want 0", bus.tx_ready); end
    bus.tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (acc_total - ab !== 4) begin failures++; $display("FAIL hs_accepts: got %0d want 4", acc_total - ab); end
    checks++; if (und_total - ub !== 0) begin failures++; $display("FAIL hs_underruns: got %0d want 0", und_total - ub); end
    checks++; if (rx_total - rb !== 2)  begin failures++; $display("FAIL hs_rx_count: got %0d want 2", rx_total - rb); end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      checks++; if (rx_log[rb+k] !== e) begin failures++; $display("FAIL hs_rx_word%0d: got %h want %h", k, rx_log[rb+k], e); end
      k++;
    end
    k = 0;
    while (exp_miso.size() > 0) begin
      e = exp_miso.pop_front();
      checks++; if (obs_miso[0] !== e) begin failures++; $display("FAIL hs_miso%0d: got %h want %h", k, obs_miso[0], e); end
      void'(obs_miso.pop_front());
      k++;
    end
  endtask

  initial begin
    bus.spi_clk  = 1'b0;
    bus.cs       = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    test_handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
